// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: three writers, one port, plus the
// issue-stage scoreboard of registers with writes still outstanding.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int SEL_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              req_valid,
    input  logic [3*SEL_WIDTH-1:0]  req_sel,
    input  logic [3*DATA_WIDTH-1:0] req_data,
    output logic [2:0]              req_ready,
    input  logic                    rsv_en,
    input  logic [SEL_WIDTH-1:0]    rsv_sel,
    output logic                    rsv_conflict,
    output logic [NUM_REGS-1:0]     pending,
    output logic                    out_write_en,
    output logic [SEL_WIDTH-1:0]    out_write_sel,
    output logic [DATA_WIDTH-1:0]   out_write_data
);

    logic [2:0]            grant;
    logic                  xfer;
    logic [SEL_WIDTH-1:0]  win_sel;
    logic [DATA_WIDTH-1:0] win_data;

    logic [1:0]            rr_last_q, rr_last_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  wen_q, wen_d;
    logic [SEL_WIDTH-1:0]  wsel_q, wsel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Requester 0 always wins; 1 and 2 alternate via rr_last.
    always_comb begin
        grant = 3'b000;
        if (reset_n) begin
            if (req_valid[0]) begin
                grant = 3'b001;
            end else if (req_valid[1] && req_valid[2]) begin
                grant = (rr_last_q == 2'd2) ? 3'b010 : 3'b100;
            end else if (req_valid[1]) begin
                grant = 3'b010;
            end else if (req_valid[2]) begin
                grant = 3'b100;
            end
        end
    end

    always_comb begin
        win_sel  = '0;
        win_data = '0;
        unique case (1'b1)
            grant[0]: begin
                win_sel  = req_sel[0*SEL_WIDTH +: SEL_WIDTH];
                win_data = req_data[0*DATA_WIDTH +: DATA_WIDTH];
            end
            grant[1]: begin
                win_sel  = req_sel[1*SEL_WIDTH +: SEL_WIDTH];
                win_data = req_data[1*DATA_WIDTH +: DATA_WIDTH];
            end
            grant[2]: begin
                win_sel  = req_sel[2*SEL_WIDTH +: SEL_WIDTH];
                win_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign xfer      = |grant;
    assign req_ready = grant;

    assign rsv_conflict = reset_n && rsv_en && (rsv_sel != '0)
                          && pending_q[rsv_sel];

    always_comb begin
        rr_last_d = rr_last_q;
        pending_d = pending_q;
        wen_d     = 1'b0;
        wsel_d    = wsel_q;
        wdata_d   = wdata_q;
        if (xfer) begin
            wen_d   = (win_sel != '0);
            wsel_d  = win_sel;
            wdata_d = win_data;
            if (grant[1]) rr_last_d = 2'd1;
            if (grant[2]) rr_last_d = 2'd2;
            if (win_sel != '0) pending_d[win_sel] = 1'b0;
        end
        // Set after clear so a same-cycle reservation wins.
        if (rsv_en && (rsv_sel != '0) && !rsv_conflict) begin
            pending_d[rsv_sel] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_last_q <= 2'd2;
            pending_q <= '0;
            wen_q     <= 1'b0;
            wsel_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            pending_q <= pending_d;
            wen_q     <= wen_d;
            wsel_q    <= wsel_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pending        = pending_q;
    assign out_write_en   = wen_q;
    assign out_write_sel  = wsel_q;
    assign out_write_data = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus
// hand-written latency, hold and mid-stream reset sequences.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [11:0] req_sel;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_en;
    logic [3:0]  rsv_sel;
    logic        rsv_conflict;
    logic [15:0] pending;
    logic        out_write_en;
    logic [3:0]  out_write_sel;
    logic [31:0] out_write_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_sel        (req_sel),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsv_en         (rsv_en),
        .rsv_sel        (rsv_sel),
        .rsv_conflict   (rsv_conflict),
        .pending        (pending),
        .out_write_en   (out_write_en),
        .out_write_sel  (out_write_sel),
        .out_write_data (out_write_data)
    );

    typedef struct {
        logic [2:0]  vld;
        logic [3:0]  s0, s1, s2;
        logic        ren;
        logic [3:0]  rsel;
        logic [2:0]  rdy;
        logic        cf;
        logic        en;
        logic [3:0]  esel;
        logic [15:0] pend;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [31:0] dat(input int i, input logic [3:0] s);
        logic [1:0] ii;
        ii = i[1:0];
        return {16'hC0DE, 6'd0, ii, 4'd0, s};
    endfunction

    function automatic vec_t mk(
        input logic [2:0] vld, input logic [3:0] s0, s1, s2,
        input logic ren, input logic [3:0] rsel, input logic [2:0] rdy,
        input logic cf, input logic en, input logic [3:0] esel,
        input logic [15:0] pend);
        vec_t v;
        v.vld = vld; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.ren = ren; v.rsel = rsel; v.rdy = rdy; v.cf = cf;
        v.en = en; v.esel = esel; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] vld,
                         input logic [3:0] s0, s1, s2,
                         input logic ren, input logic [3:0] rsel);
        req_valid = vld;
        req_sel   = {s2, s1, s0};
        req_data  = {dat(2, s2), dat(1, s1), dat(0, s0)};
        rsv_en    = ren;
        rsv_sel   = rsel;
    endtask

    // Requesters must hold sel/data while waiting for a grant.
    logic [2:0]  p_wait;
    logic [11:0] p_sel;
    logic [95:0] p_data;
    logic        p_rst = 1'b0;
    always @(posedge clk) begin
        if (p_rst && reset_n) begin
            for (int i = 0; i < 3; i++) begin
                if (p_wait[i] && req_valid[i]) begin
                    n_chk++;
                    if (req_sel[i*4 +: 4] !== p_sel[i*4 +: 4] ||
                        req_data[i*32 +: 32] !== p_data[i*32 +: 32]) begin
                        n_fail++;
                        $display("FAIL hold_stable req%0d: got %h expected %h",
                                 i, req_sel[i*4 +: 4], p_sel[i*4 +: 4]);
                    end
                end
            end
        end
        p_rst  <= reset_n;
        p_wait <= req_valid & ~req_ready;
        p_sel  <= req_sel;
        p_data <= req_data;
    end

    initial begin
        //               vld     s0    s1    s2   ren rsel  rdy    cf en esel  pend
        tbl[0]  = mk(3'b111, 4'd3, 4'd5, 4'd7, 0, 4'd0, 3'b001, 0, 1, 4'd3, 16'h0000);
        tbl[1]  = mk(3'b110, 4'd3, 4'd5, 4'd7, 0, 4'd0, 3'b010, 0, 1, 4'd5, 16'h0000);
        tbl[2]  = mk(3'b110, 4'd3, 4'd5, 4'd7, 0, 4'd0, 3'b100, 0, 1, 4'd7, 16'h0000);
        tbl[3]  = mk(3'b110, 4'd3, 4'd5, 4'd7, 0, 4'd0, 3'b010, 0, 1, 4'd5, 16'h0000);
        tbl[4]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd6, 3'b000, 0, 0, 4'd0, 16'h0040);
        tbl[5]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd6, 3'b000, 1, 0, 4'd0, 16'h0040);
        tbl[6]  = mk(3'b010, 4'd0, 4'd6, 4'd0, 0, 4'd0, 3'b010, 0, 1, 4'd6, 16'h0000);
        tbl[7]  = mk(3'b100, 4'd0, 4'd0, 4'd9, 1, 4'd9, 3'b100, 0, 1, 4'd9, 16'h0200);
        tbl[8]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd0, 3'b000, 0, 0, 4'd0, 16'h0200);
        tbl[9]  = mk(3'b001, 4'd0, 4'd0, 4'd0, 0, 4'd0, 3'b001, 0, 0, 4'd0, 16'h0200);
        tbl[10] = mk(3'b100, 4'd0, 4'd0, 4'd4, 0, 4'd0, 3'b100, 0, 1, 4'd4, 16'h0200);
        tbl[11] = mk(3'b001, 4'd9, 4'd0, 4'd0, 1, 4'd9, 3'b001, 1, 1, 4'd9, 16'h0000);
        tbl[12] = mk(3'b011, 4'd2, 4'd3, 4'd0, 1, 4'd2, 3'b001, 0, 1, 4'd2, 16'h0004);
        tbl[13] = mk(3'b110, 4'd0, 4'd3, 4'd8, 0, 4'd0, 3'b010, 0, 1, 4'd3, 16'h0004);
        tbl[14] = mk(3'b111, 4'd10, 4'd3, 4'd8, 0, 4'd0, 3'b001, 0, 1, 4'd10, 16'h0004);
        tbl[15] = mk(3'b110, 4'd0, 4'd3, 4'd8, 0, 4'd0, 3'b100, 0, 1, 4'd8, 16'h0004);
        tbl[16] = mk(3'b010, 4'd0, 4'd3, 4'd0, 0, 4'd0, 3'b010, 0, 1, 4'd3, 16'h0004);

        reset_n = 1'b0;
        drive(3'b111, 4'd3, 4'd5, 4'd7, 1, 4'd5);
        tick();
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_conflict", 32'(rsv_conflict), 32'h0);
        chk("rst_wen", 32'(out_write_en), 32'h0);
        chk("rst_wsel", 32'(out_write_sel), 32'h0);
        chk("rst_wdata", out_write_data, 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            int g;
            drive(tbl[i].vld, tbl[i].s0, tbl[i].s1, tbl[i].s2,
                  tbl[i].ren, tbl[i].rsel);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_conflict", i), 32'(rsv_conflict), 32'(tbl[i].cf));
            tick();
            chk($sformatf("v%0d_wen", i), 32'(out_write_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            if (tbl[i].en) begin
                g = tbl[i].rdy[0] ? 0 : (tbl[i].rdy[1] ? 1 : 2);
                chk($sformatf("v%0d_wsel", i), 32'(out_write_sel), 32'(tbl[i].esel));
                chk($sformatf("v%0d_wdata", i), out_write_data, dat(g, tbl[i].esel));
            end
        end

        // One-cycle latency, then output drops and sel/data hold.
        drive(3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0);
        req_valid = 3'b010;
        req_sel   = {4'd0, 4'd4, 4'd0};
        req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
        #1;
        chk("lat_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 3'b000;
        chk("lat_wen", 32'(out_write_en), 32'h1);
        chk("lat_wsel", 32'(out_write_sel), 32'h4);
        chk("lat_wdata", out_write_data, 32'hDEADBEEF);
        tick();
        chk("lat_wen_off", 32'(out_write_en), 32'h0);
        chk("hold_wsel", 32'(out_write_sel), 32'h4);
        chk("hold_wdata", out_write_data, 32'hDEADBEEF);

        // Back-to-back requester-0 writes, then reset mid-stream.
        for (int k = 1; k <= 3; k++) begin
            drive(3'b001, 4'(k + 10), 4'd0, 4'd0, 0, 4'd0);
            tick();
            chk($sformatf("b2b%0d_wen", k), 32'(out_write_en), 32'h1);
            chk($sformatf("b2b%0d_wsel", k), 32'(out_write_sel), 32'(k + 10));
        end
        reset_n = 1'b0;
        drive(3'b001, 4'd14, 4'd0, 4'd0, 1, 4'd11);
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_conflict", 32'(rsv_conflict), 32'h0);
        tick();
        chk("mid_rst_wen", 32'(out_write_en), 32'h0);
        chk("mid_rst_pending", 32'(pending), 32'h0);
        reset_n = 1'b1;

        // rr_last returns to 2, so requester 1 wins the tie.
        drive(3'b110, 4'd0, 4'd5, 4'd7, 0, 4'd0);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h2);
        tick();
        chk("post_rst_wsel", 32'(out_write_sel), 32'h5);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
